// File: rtl/fir_serial_pkg.sv
// Shared types and width helpers for the parametrised serial FIR.
//   state_t   : controller state (IDLE waits for a sample, MAC runs the taps)
//   clog2     : ceil(log2(n)) for n >= 1
//   acc_width : accumulator width that cannot overflow for TAPS products
package fir_serial_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      MAC  = 1'b1
   } state_t;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned v = n - 1; v != 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

   function automatic int unsigned acc_width(input int unsigned dw,
                                             input int unsigned cw,
                                             input int unsigned taps);
      return dw + cw + clog2(taps);
   endfunction

endpackage

// File: rtl/fir_serial_param_if.sv
// Sample and coefficient bus of the serial FIR.
//   master : upstream side, drives samples and coefficient writes
//   slave  : filter side, returns ready, pending flag and filtered output
interface fir_serial_param_if #(
   parameter int unsigned TAPS = 6,
   parameter int unsigned DW   = 16,
   parameter int unsigned CW   = 16
);
   import fir_serial_pkg::*;

   localparam int unsigned ADDR_W = clog2(TAPS);

   logic                     in_valid;
   logic                     in_ready;
   logic signed [DW-1:0]     filter_in;
   logic                     coef_we;
   logic        [ADDR_W-1:0] coef_addr;
   logic signed [CW-1:0]     coef_wdata;
   logic                     coef_swap;
   logic                     coef_pending;
   logic                     out_valid;
   logic signed [DW-1:0]     filter_out;

   modport master (
      output in_valid, filter_in, coef_we, coef_addr, coef_wdata, coef_swap,
      input  in_ready, coef_pending, out_valid, filter_out
   );

   modport slave (
      input  in_valid, filter_in, coef_we, coef_addr, coef_wdata, coef_swap,
      output in_ready, coef_pending, out_valid, filter_out
   );

endinterface

// File: rtl/fir_round_sat.sv
// Convergent (round-half-to-even) right shift followed by saturate or wrap.
//   din    : signed value, IW bits
//   dout_c : signed result, OW bits, equal to round(din / 2^SHIFT) clamped
//            to OW bits when SAT != 0, otherwise its low OW bits
module fir_round_sat #(
   parameter int unsigned IW    = 35,
   parameter int unsigned SHIFT = 16,
   parameter int unsigned OW    = 16,
   parameter int unsigned SAT   = 1
) (
   input  logic signed [IW-1:0] din,
   output logic signed [OW-1:0] dout_c
);

   localparam int unsigned        TW   = IW - SHIFT;
   localparam logic [SHIFT-1:0]   HALF = SHIFT'(1) << (SHIFT - 1);
   localparam logic signed [OW-1:0] MAXV = {1'b0, {(OW-1){1'b1}}};
   localparam logic signed [OW-1:0] MINV = {1'b1, {(OW-1){1'b0}}};

   logic signed [TW-1:0]  trunc_c;
   logic        [SHIFT-1:0] frac_c;
   logic                  up_c;
   logic signed [TW:0]    rnd_c;
   logic                  fits_c;

   assign trunc_c = din[IW-1:SHIFT];
   assign frac_c  = din[SHIFT-1:0];

   // Round up above one half; at exactly one half only when that makes the result even.
   assign up_c = (frac_c > HALF) || ((frac_c == HALF) && trunc_c[0]);

   // One extra bit so the increment can never wrap.
   assign rnd_c = (TW+1)'(trunc_c) + (TW+1)'(up_c);

   // Representable in OW bits when everything above the OW sign bit matches it.
   assign fits_c = (rnd_c[TW:OW-1] == '0) || (rnd_c[TW:OW-1] == '1);

   always_comb begin
      dout_c = rnd_c[OW-1:0];
      if ((SAT != 0) && !fits_c) begin
         dout_c = rnd_c[TW] ? MINV : MAXV;
      end
   end

endmodule

// File: rtl/fir_serial_param.sv
// Fully serial direct-form FIR: one MAC, TAPS cycles per sample, double-buffered
// coefficients, convergent rounding and selectable saturate/wrap output.
//   clk, syn_rst : clock and synchronous active-high reset
//   clk_enable   : global enable, every register holds while low
//   bus (slave)  : in_valid/in_ready/filter_in sample input,
//                  coef_we/coef_addr/coef_wdata shadow-bank write,
//                  coef_swap/coef_pending bank swap request,
//                  out_valid/filter_out filtered output
module fir_serial_param
   import fir_serial_pkg::*;
#(
   parameter int unsigned TAPS = 6,
   parameter int unsigned DW   = 16,
   parameter int unsigned CW   = 16,
   parameter int unsigned SAT  = 1
) (
   input  logic               clk,
   input  logic               syn_rst,
   input  logic               clk_enable,
   fir_serial_param_if.slave  bus
);

   localparam int unsigned CNTW = clog2(TAPS);
   localparam int unsigned PW   = DW + CW;
   localparam int unsigned AW   = acc_width(DW, CW, TAPS);

   state_t               state;
   logic [CNTW-1:0]      count;
   logic signed [DW-1:0] delay       [TAPS];
   logic signed [CW-1:0] coef_shadow [TAPS];
   logic signed [CW-1:0] coef_active [TAPS];
   logic signed [AW-1:0] acc;
   logic                 coef_pending;
   logic                 out_valid;
   logic signed [DW-1:0] filter_out;

   logic signed [PW-1:0] prod_c;
   logic signed [AW-1:0] mac_sum_c;
   logic signed [DW-1:0] rs_out_c;
   logic                 copy_c;
   logic                 last_c;

   // Bank swap is only allowed between samples so a MAC pass sees one coefficient set.
   assign copy_c = (state == IDLE) && coef_pending;
   assign last_c = (count == CNTW'(TAPS - 1));

   // Single multiplier; the first tap of a pass restarts the accumulation.
   assign prod_c    = PW'(delay[count]) * PW'(coef_active[count]);
   assign mac_sum_c = ((count == '0) ? '0 : acc) + AW'(prod_c);

   fir_round_sat #(
      .IW    (AW),
      .SHIFT (CW),
      .OW    (DW),
      .SAT   (SAT)
   ) u_round_sat (
      .din    (mac_sum_c),
      .dout_c (rs_out_c)
   );

   // Controller, datapath and coefficient banks.
   always_ff @(posedge clk) begin
      if (syn_rst) begin
         state        <= IDLE;
         count        <= '0;
         acc          <= '0;
         coef_pending <= 1'b0;
         out_valid    <= 1'b0;
         filter_out   <= '0;
         for (int unsigned k = 0; k < TAPS; k++) begin
            delay[k]       <= '0;
            coef_shadow[k] <= '0;
            coef_active[k] <= '0;
         end
      end else if (clk_enable) begin
         out_valid <= 1'b0;

         if (bus.coef_we && (32'(bus.coef_addr) < TAPS)) begin
            coef_shadow[bus.coef_addr] <= bus.coef_wdata;
         end

         // A swap request arriving on the copy edge is absorbed by that copy.
         if (copy_c) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
               coef_active[k] <= coef_shadow[k];
            end
            coef_pending <= 1'b0;
         end else if (bus.coef_swap) begin
            coef_pending <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  delay[0] <= bus.filter_in;
                  for (int unsigned k = 1; k < TAPS; k++) begin
                     delay[k] <= delay[k-1];
                  end
                  count <= '0;
                  state <= MAC;
               end
            end
            MAC: begin
               acc <= mac_sum_c;
               if (last_c) begin
                  filter_out <= rs_out_c;
                  out_valid  <= 1'b1;
                  count      <= '0;
                  state      <= IDLE;
               end else begin
                  count <= count + CNTW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready     = (state == IDLE);
   assign bus.coef_pending = coef_pending;
   assign bus.out_valid    = out_valid;
   assign bus.filter_out   = filter_out;

endmodule

// File: tb/tb_fir_serial_param.sv
// Bench for fir_serial_param: a saturating and a wrapping instance share the
// same stimulus; expected outputs go into per-instance queues and are popped
// when out_valid is seen on an enabled cycle.
module tb_fir_serial_param;

   localparam int unsigned TAPS = 6;
   localparam int unsigned DW   = 16;
   localparam int unsigned CW   = 16;

   logic clk = 1'b0;
   logic rst;
   logic clk_enable;

   always #5 clk = ~clk;

   fir_serial_param_if #(.TAPS(TAPS), .DW(DW), .CW(CW)) bus_s ();
   fir_serial_param_if #(.TAPS(TAPS), .DW(DW), .CW(CW)) bus_w ();

   assign bus_w.in_valid   = bus_s.in_valid;
   assign bus_w.filter_in  = bus_s.filter_in;
   assign bus_w.coef_we    = bus_s.coef_we;
   assign bus_w.coef_addr  = bus_s.coef_addr;
   assign bus_w.coef_wdata = bus_s.coef_wdata;
   assign bus_w.coef_swap  = bus_s.coef_swap;

   fir_serial_param #(.TAPS(TAPS), .DW(DW), .CW(CW), .SAT(1)) dut_s (
      .clk        (clk),
      .syn_rst    (rst),
      .clk_enable (clk_enable),
      .bus        (bus_s.slave)
   );

   fir_serial_param #(.TAPS(TAPS), .DW(DW), .CW(CW), .SAT(0)) dut_w (
      .clk        (clk),
      .syn_rst    (rst),
      .clk_enable (clk_enable),
      .bus        (bus_w.slave)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_cyc = 0;
   int out_cyc = 0;
   int out_cnt = 0;

   logic [15:0] q_s[$];
   logic [15:0] q_w[$];
   logic [15:0] e_s, e_w;

   // Reference state: sample history, shadow and active coefficients.
   int hist[TAPS];
   int act[TAPS];
   int shd[TAPS];

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: compare each output against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && clk_enable) begin
         if (bus_s.out_valid) begin
            total++;
            out_cyc = cyc;
            out_cnt++;
            if (q_s.size() == 0) begin
               bad++;
               $display("FAIL sat_out unexpected out_valid got=%h", bus_s.filter_out);
            end else begin
               e_s = q_s.pop_front();
               if (bus_s.filter_out !== e_s) begin
                  bad++;
                  $display("FAIL sat_out got=%h want=%h", bus_s.filter_out, e_s);
               end
            end
         end
         if (bus_w.out_valid) begin
            total++;
            if (q_w.size() == 0) begin
               bad++;
               $display("FAIL wrap_out unexpected out_valid got=%h", bus_w.filter_out);
            end else begin
               e_w = q_w.pop_front();
               if (bus_w.filter_out !== e_w) begin
                  bad++;
                  $display("FAIL wrap_out got=%h want=%h", bus_w.filter_out, e_w);
               end
            end
         end
      end
   end

   // Exact sum, divide by 2^16 with ties to even, then clamp or wrap.
   function automatic logic [15:0] model(input bit sat);
      longint s, q, r;
      s = 0;
      for (int k = 0; k < TAPS; k++) s += longint'(hist[k]) * longint'(act[k]);
      q = s >>> 16;
      r = s - q * 65536;
      if (r > 32768 || (r == 32768 && (q % 2 != 0))) q++;
      if (sat) begin
         if (q > 32767) q = 32767;
         else if (q < -32768) q = -32768;
      end
      return 16'(q);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int k = 0; k < TAPS; k++) begin
         hist[k] = 0;
         act[k]  = 0;
         shd[k]  = 0;
      end
   endtask

   task automatic model_accept(input logic [15:0] x);
      for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'($signed(x));
   endtask

   task automatic push_model();
      q_s.push_back(model(1'b1));
      q_w.push_back(model(1'b0));
   endtask

   task automatic push_const(input logic [15:0] vs, input logic [15:0] vw);
      q_s.push_back(vs);
      q_w.push_back(vw);
   endtask

   // Offer one sample and wait (bounded) until it is accepted.
   task automatic send(input logic [15:0] x);
      int n;
      bus_s.in_valid  = 1'b1;
      bus_s.filter_in = x;
      n = 0;
      while (!bus_s.in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!bus_s.in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout in_ready got=%b want=1", bus_s.in_ready);
      end
      tick();
      acc_cyc = cyc;
      bus_s.in_valid = 1'b0;
      model_accept(x);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q_s.size() != 0 || q_w.size() != 0) && n < 60) begin
         tick();
         n++;
      end
      if (q_s.size() != 0 || q_w.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout pending got=%0d want=0", q_s.size() + q_w.size());
         q_s.delete();
         q_w.delete();
      end
   endtask

   task automatic load_coefs(input int c[TAPS]);
      for (int k = 0; k < TAPS; k++) begin
         bus_s.coef_we    = 1'b1;
         bus_s.coef_addr  = 3'(k);
         bus_s.coef_wdata = 16'(c[k]);
         shd[k] = c[k];
         tick();
      end
      bus_s.coef_we   = 1'b0;
      bus_s.coef_swap = 1'b1;
      tick();
      bus_s.coef_swap = 1'b0;
      tick();
      for (int k = 0; k < TAPS; k++) act[k] = shd[k];
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++; if (bus_s.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus_s.in_ready); end
      total++; if (bus_s.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus_s.out_valid); end
      total++; if (bus_s.filter_out !== 16'h0000) begin bad++; $display("FAIL reset_filter_out got=%h want=0000", bus_s.filter_out); end
      total++; if (bus_s.coef_pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b want=0", bus_s.coef_pending); end
      rst = 1'b0;
      model_reset();
      tick();
   endtask

   task automatic test_impulse();
      int c[TAPS];
      c = '{32'h2000, 0, 0, 0, 0, 0};
      load_coefs(c);
      for (int i = 0; i < 7; i++) begin
         send((i == 0) ? 16'h4000 : 16'h0000);
         push_const((i == 0) ? 16'h0800 : 16'h0000, (i == 0) ? 16'h0800 : 16'h0000);
         drain();
         total++;
         if (out_cyc - acc_cyc !== int'(TAPS)) begin
            bad++;
            $display("FAIL impulse_latency got=%0d want=%0d", out_cyc - acc_cyc, TAPS);
         end
      end
   endtask

   task automatic test_rounding();
      int c[TAPS];
      c = '{32'h4000, 0, 0, 0, 0, 0};
      load_coefs(c);
      send(16'h0002); push_const(16'h0000, 16'h0000); drain();
      send(16'h0006); push_const(16'h0002, 16'h0002); drain();
      send(16'hFFFA); push_const(16'hFFFE, 16'hFFFE); drain();
   endtask

   task automatic test_overflow();
      int c[TAPS];
      c = '{32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF};
      load_coefs(c);
      for (int i = 0; i < 6; i++) begin
         send(16'h7FFF);
         if (i < 5) push_model();
         else push_const(16'h7FFF, 16'h7FFA);
      end
      drain();
   endtask

   task automatic test_swap();
      int c_old[TAPS];
      int c_new[TAPS];
      c_old = '{32'h4000, 32'h2000, 32'h1000, 32'h0800, 32'h0400, 32'h0200};
      c_new = '{32'h1000, -32'sd2048, 32'h0400, 32'h0200, 32'h0100, 32'h0080};
      load_coefs(c_old);
      send(16'h1234);
      push_model();
      // Rewrite the shadow bank and request the swap while the old pass runs.
      for (int t = 0; t < TAPS; t++) begin
         bus_s.coef_we    = 1'b1;
         bus_s.coef_addr  = 3'(t);
         bus_s.coef_wdata = 16'(c_new[t]);
         bus_s.coef_swap  = (t == 3);
         tick();
         if (t >= 3) begin
            total++;
            if (bus_s.coef_pending !== 1'b1) begin
               bad++;
               $display("FAIL swap_pending_held step=%0d got=%b want=1", t, bus_s.coef_pending);
            end
         end
      end
      bus_s.coef_we   = 1'b0;
      bus_s.coef_swap = 1'b0;
      for (int k = 0; k < TAPS; k++) begin
         shd[k] = c_new[k];
         act[k] = c_new[k];
      end
      send(16'h2000);
      push_model();
      total++;
      if (bus_s.coef_pending !== 1'b0) begin
         bad++;
         $display("FAIL swap_pending_clear got=%b want=0", bus_s.coef_pending);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [15:0] vals[4];
      int prev;
      int n;
      vals = '{16'h0100, 16'hF000, 16'h3000, 16'h8000};
      prev = 0;
      bus_s.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus_s.filter_in = vals[i];
         n = 0;
         while (!bus_s.in_ready && n < 50) begin
            tick();
            n++;
         end
         tick();
         model_accept(vals[i]);
         push_model();
         if (i > 0) begin
            total++;
            if (cyc - prev !== int'(TAPS) + 1) begin
               bad++;
               $display("FAIL b2b_spacing got=%0d want=%0d", cyc - prev, TAPS + 1);
            end
         end
         prev = cyc;
      end
      bus_s.in_valid = 1'b0;
      drain();
   endtask

   task automatic test_enable();
      int cnt0;
      // Stall three cycles in the middle of the MAC pass.
      send(16'h1111);
      push_model();
      tick();
      tick();
      clk_enable = 1'b0;
      repeat (3) tick();
      clk_enable = 1'b1;
      drain();
      total++;
      if (out_cyc - acc_cyc !== int'(TAPS) + 3) begin
         bad++;
         $display("FAIL enable_latency got=%0d want=%0d", out_cyc - acc_cyc, TAPS + 3);
      end
      // Stall while out_valid is high: it must hold, then count once.
      cnt0 = out_cnt;
      send(16'h2222);
      push_model();
      repeat (TAPS) tick();
      clk_enable = 1'b0;
      total++;
      if (bus_s.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL enable_out_valid_rise got=%b want=1", bus_s.out_valid);
      end
      tick();
      tick();
      total++;
      if (bus_s.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL enable_out_valid_hold got=%b want=1", bus_s.out_valid);
      end
      clk_enable = 1'b1;
      drain();
      tick();
      total++;
      if (out_cnt - cnt0 !== 1) begin
         bad++;
         $display("FAIL enable_out_once got=%0d want=1", out_cnt - cnt0);
      end
   endtask

   task automatic test_reset_mac();
      int cnt0;
      send(16'h5555);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      total++; if (bus_s.in_ready !== 1'b1) begin bad++; $display("FAIL rstmac_in_ready got=%b want=1", bus_s.in_ready); end
      total++; if (bus_s.out_valid !== 1'b0) begin bad++; $display("FAIL rstmac_out_valid got=%b want=0", bus_s.out_valid); end
      total++; if (bus_s.filter_out !== 16'h0000) begin bad++; $display("FAIL rstmac_filter_out got=%h want=0000", bus_s.filter_out); end
      total++; if (bus_w.filter_out !== 16'h0000) begin bad++; $display("FAIL rstmac_wrap_filter_out got=%h want=0000", bus_w.filter_out); end
      cnt0 = out_cnt;
      repeat (TAPS + 2) tick();
      total++;
      if (out_cnt !== cnt0) begin
         bad++;
         $display("FAIL rstmac_no_output got=%0d want=0", out_cnt - cnt0);
      end
      // Active bank cleared: nonzero input gives zero output.
      send(16'h1000);
      push_const(16'h0000, 16'h0000);
      drain();
      // Only tap 0 rewritten; other shadow taps and the delay line must be zero.
      bus_s.coef_we    = 1'b1;
      bus_s.coef_addr  = 3'd0;
      bus_s.coef_wdata = 16'h4000;
      tick();
      bus_s.coef_we   = 1'b0;
      bus_s.coef_swap = 1'b1;
      tick();
      bus_s.coef_swap = 1'b0;
      tick();
      send(16'h2000);
      push_const(16'h0800, 16'h0800);
      drain();
   endtask

   initial begin
      rst              = 1'b1;
      clk_enable       = 1'b1;
      bus_s.in_valid   = 1'b0;
      bus_s.filter_in  = '0;
      bus_s.coef_we    = 1'b0;
      bus_s.coef_addr  = '0;
      bus_s.coef_wdata = '0;
      bus_s.coef_swap  = 1'b0;
      model_reset();

      test_reset();
      test_impulse();
      test_rounding();
      test_overflow();
      test_swap();
      test_back_to_back();
      test_enable();
      test_reset_mac();

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fir_serial_param.md
# fir_serial_param

Parametrised fully-serial direct-form FIR with one multiplier-accumulator, run-time loadable coefficients and a valid/ready sample interface. It generalises the fixed 6-tap serial filter to any tap count and width. It adds double-buffered coefficient update, convergent rounding and selectable saturate/wrap on the output. It sits in the baseband receive/transmit chains wherever sample rate is at most clk/(TAPS+1).

## Interface
- TAPS, 6: number of taps, 2..64
- DW, 16: input/output width, signed, fraction DW-1 bits
- CW, 16: coefficient width, signed, fraction CW bits
- SAT, 1: 1 saturates the output on overflow, 0 wraps
- clk  in  1  single clock
- syn_rst  in  1  synchronous, active-high reset
- clk_enable  in  1  global enable; when low, all registers hold
- in_valid  in  1  filter_in is valid
- in_ready  out  1  block can accept a sample; equals (state==IDLE)
- filter_in  in  DW  input sample
- coef_we  in  1  write coef_wdata into shadow bank
- coef_addr  in  clog2(TAPS)  shadow tap index; addresses >= TAPS are ignored
- coef_wdata  in  CW  coefficient value
- coef_swap  in  1  request shadow-to-active copy
- coef_pending  out  1  swap requested, not yet applied
- out_valid  out  1  filter_out is new (one enabled cycle)
- filter_out  out  DW  filtered sample, fraction DW-1

## Operation
- Reset: state IDLE, count 0, delay line 0, accumulator 0, both coefficient banks 0, coef_pending 0, out_valid 0, filter_out 0, in_ready 1.
- All updates are qualified by clk_enable. With clk_enable low nothing changes, including out_valid.
- FSM states:
  - IDLE: accept on in_valid & in_ready. Shift filter_in into delay[0], delay[k] <= delay[k-1]. Go to MAC, count=0.
  - MAC: acc <= (count==0 ? 0 : acc) + delay[count]*coef_active[count]. Count increments each cycle.
  - When count==TAPS-1: register round_sat(acc + product) into filter_out, set out_valid=1, go to IDLE.
- out_valid clears on the next enabled cycle.
- Widths:
  - Product is DW+CW bits with fraction DW+CW-1.
  - Accumulator is DW+CW+clog2(TAPS) bits; no internal overflow is possible.
  - Output is the accumulator shifted right by CW bits.
- Rounding is convergent: round half to even on the CW discarded bits.
- Overflow:
  - SAT=1: clamp to +/-full scale, i.e. 2^(DW-1)-1 and -2^(DW-1).
  - SAT=0: keep the low DW bits.
- Coefficients:
  - coef_we writes the shadow bank at any time.
  - coef_swap sets coef_pending.
  - When pending and state==IDLE, copy shadow to active and clear pending. This happens in the same cycle as any accept, so a sample accepted in that cycle uses the new set.
  - The active bank never changes during MAC.
  - coef_swap while pending is already set has no extra effect.
  - coef_we and coef_swap in the same cycle: the write lands before the copy decision. The copy happens at a later IDLE edge, so it includes that write.

## Timing
- Latency: accept edge E0, MAC edges E1..E(TAPS). out_valid is high in the cycle after E(TAPS), so TAPS cycles after accept.
- in_ready rises in the same cycle out_valid is high.
- Maximum throughput: one sample per TAPS+1 enabled cycles.
- in_valid while in_ready=0 is not consumed; the upstream block holds the sample.
- syn_rst during MAC aborts the sample: no out_valid, and the delay line is cleared.
- filter_out holds its last value until the next out_valid.

## Structure
- fir_serial_pkg holds:
  - the state enum {IDLE, MAC};
  - a clog2 function;
  - the accumulator-width function.
- Sub-module fir_round_sat holds the convergent rounding and saturate/wrap logic. It is combinational and parametrised by input width, shift and SAT.
- Coefficient banks are flip-flop arrays, not RAM, so all taps can be copied in a single cycle.

## Test plan
- Impulse:
  - Setup: TAPS=6, DW=16, CW=16. Load coefficients 0x2000 at tap 0 and 0 elsewhere, then swap.
  - Stimulus: filter_in=0x4000 followed by zeros.
  - Required: first output 0x0800, later outputs 0. out_valid exactly 6 cycles after each accept.
- Convergent rounding (single coefficient 0x4000):
  - Input 0x0002: exact 0.5, output 0x0000.
  - Input 0x0006: exact 1.5, output 0x0002.
  - Input 0xFFFA: exact -1.5, output 0xFFFE.
- Overflow, all six coefficients 0x7FFF, input 0x7FFF held for 6 samples:
  - SAT=1: output saturates to 0x7FFF.
  - SAT=0: output wraps to 0x7FFA.
- Coefficient swap:
  - Stimulus: write a new set and pulse coef_swap during MAC.
  - Required: the in-flight output uses the old set, coef_pending stays 1 until IDLE, and the next sample uses the new set.
- Back-pressure and enable:
  - Stimulus: in_valid held high continuously.
  - Required: accepts spaced exactly 7 cycles apart.
  - Stimulus: clk_enable low for 3 cycles mid-MAC.
  - Required: latency stretches by 3 cycles; out_valid still lasts one enabled cycle.
- Reset:
  - Stimulus: syn_rst for one cycle during MAC.
  - Required: no out_valid, in_ready=1 on the next cycle, filter_out=0, and both coefficient banks are 0.
